cache_ahb_master: RTL and testbench
===================================

# cache_ahb_master

AHB-Lite burst master that services cache block refills and write-backs. Sits between the cache controller and the AHB slave: accepts one block request at a time and converts it into a single 8-beat INCR8 burst of 32-bit words. For a refill it assembles the returned beats into a BLOCK_WIDTH line; for a write-back it serialises a line onto HWDATA. It then returns a completion with error status to the cache.

## Interface
- WORD_WIDTH, 32, bus word width in bits
- BLOCK_WIDTH, 256, cache line width in bits
- BLOCK_WIDTH_WORDS, 8, words per line (= beats per burst)
- LOG2_BLOCK_WIDTH_WORDS, 3, beat counter width
- LOG2_BLOCK_SIZE, 5, line offset bits in a byte address
- ADDR_WIDTH, 32, address width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  cache request valid
- req_ready  out  1  block idle, can accept request
- req_write  in  1  1 = write-back, 0 = refill
- req_addr  in  ADDR_WIDTH  any byte address inside the target line
- req_wdata  in  BLOCK_WIDTH  write-back line, word k at bits [32k+31:32k]
- resp_valid  out  1  completion valid, held until resp_ready
- resp_ready  in  1  cache accepts completion
- resp_data  out  BLOCK_WIDTH  refilled line, same word packing as req_wdata
- resp_error  out  1  burst terminated by HRESP error
- HADDR  out  ADDR_WIDTH  AHB address
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11
- HBURST  out  3  101 (INCR8) while HTRANS≠IDLE, else 000
- HSIZE  out  3  010 (word) while HTRANS≠IDLE, else 000
- HWRITE  out  1  copy of latched req_write during the burst
- HWDATA  out  WORD_WIDTH  write data for the beat in data phase
- HRDATA  in  WORD_WIDTH  read data
- HREADY  in  1  slave ready / phase advance
- HRESP  in  1  1 = ERROR

## Operation
- States: IDLE, BURST, DRAIN, RESP.
- IDLE: req_ready=1. On req_valid:
  - latch base = req_addr with low LOG2_BLOCK_SIZE bits cleared;
  - latch req_write and req_wdata;
  - clear the line buffer and error flag;
  - go to BURST.
- BURST address phase:
  - beat 0 is NONSEQ at base; beats 1..7 are SEQ at base+4k.
  - addr_cnt advances only on cycles with HREADY=1.
  - After beat 7 is accepted, HTRANS=IDLE and the state goes to DRAIN.
- Data phase:
  - runs one accepted cycle behind the address phase;
  - data_cnt advances on HREADY=1;
  - read: HRDATA is captured into word data_cnt;
  - write: HWDATA = req_wdata word data_cnt throughout that data phase.
- DRAIN: wait for the final data phase (HREADY=1), then go to RESP.
- RESP: resp_valid=1 with resp_data/resp_error stable. On resp_ready, go to IDLE. The earliest next request is accepted the cycle after.
- Wait states: while HREADY=0, HADDR, HTRANS, HWRITE and HWDATA are held unchanged.
- Error: HRESP=1 with HREADY=0 during any data phase:
  - next cycle HTRANS=IDLE (burst cancelled);
  - set the error flag;
  - wait for HREADY=1, then RESP with resp_error=1.
  - Words not received remain 0; for a write-back, resp_data=0.
- Address arithmetic is modulo 2^ADDR_WIDTH; a line never crosses 1 KB, so no boundary split is needed.
- req_valid in a non-IDLE state is ignored (req_ready=0).

## Timing
- Reset values: req_ready=0 during reset, then 1 in IDLE. resp_valid=0, resp_data=0, resp_error=0, HADDR=0, HTRANS=00, HBURST=000, HSIZE=000, HWRITE=0, HWDATA=0.
- Zero-wait burst, request accepted at cycle 0:
  - NONSEQ at cycle 1;
  - SEQ at cycles 2–8;
  - data phases at cycles 2–9;
  - resp_valid first high at cycle 10.
- Each wait cycle adds exactly one cycle of latency.
- Reset asserted mid-burst: next cycle all outputs take their reset values and the state is IDLE. No response is issued for the aborted request.
- HWDATA and all address-phase outputs are registered (no combinational path from HREADY).

## Test plan
- Refill, zero-wait slave returning HRDATA = HADDR, req_addr=0x1000_0014 -> HADDR 0x1000_0000..0x1000_001C; resp_valid at cycle 10; resp_data word k = 0x1000_0000+4k; resp_error=0.
- Same refill with HREADY=0 on cycles 3 and 6 -> HADDR/HTRANS stable on those cycles; resp_valid at cycle 12; same resp_data.
- Write-back, req_wdata word k = 0xA5A5_0000+k, req_addr=0x2000_0040 -> HWRITE=1; HWDATA word k seen when the slave accepts beat k's data phase; resp_error=0.
- HRESP=1/HREADY=0 on beat 3's data phase, then HRESP=1/HREADY=1 -> HTRANS=IDLE the following cycle; resp_error=1; words 0–2 valid, words 3–7 = 0.
- resp_ready held low 5 cycles, then two back-to-back requests -> resp_valid and resp_data stable during the stall; second request accepted only after the first is retired.
- rst pulsed at cycle 5 of a refill -> HTRANS=00 and resp_valid=0 the next cycle; a new request afterwards completes normally.

Source files
------------

// File: rtl/cache_ahb_master.sv
// AHB-Lite INCR8 burst master for cache line refills and write-backs.
// One block request at a time; completion is returned with an error flag.
module cache_ahb_master #(
    parameter int WORD_WIDTH             = 32,
    parameter int BLOCK_WIDTH            = 256,
    parameter int BLOCK_WIDTH_WORDS      = 8,
    parameter int LOG2_BLOCK_WIDTH_WORDS = 3,
    parameter int LOG2_BLOCK_SIZE        = 5,
    parameter int ADDR_WIDTH             = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [BLOCK_WIDTH-1:0] req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [BLOCK_WIDTH-1:0] resp_data,
    output logic                   resp_error,
    output logic [ADDR_WIDTH-1:0]  HADDR,
    output logic [1:0]             HTRANS,
    output logic [2:0]             HBURST,
    output logic [2:0]             HSIZE,
    output logic                   HWRITE,
    output logic [WORD_WIDTH-1:0]  HWDATA,
    input  logic [WORD_WIDTH-1:0]  HRDATA,
    input  logic                   HREADY,
    input  logic                   HRESP,
    output logic [1:0]             dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // resp_valid, resp_data and resp_error stay stable until resp_ready.
    localparam int L = LOG2_BLOCK_WIDTH_WORDS;
    localparam logic [L-1:0] LAST_BEAT = L'(BLOCK_WIDTH_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << LOG2_BLOCK_SIZE) - 1);
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] HB_INCR8  = 3'b101;
    localparam logic [2:0] HS_WORD   = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_RESP} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  base;
    logic                   wr;
    logic [BLOCK_WIDTH-1:0] wdata_q;
    logic [L-1:0]           addr_cnt;
    logic [L-1:0]           data_cnt;
    logic                   data_active;
    logic                   err;
    logic [ADDR_WIDTH-1:0]  next_addr;
    logic [ADDR_WIDTH-1:0]  req_base;

    assign req_base  = req_addr & ~OFFSET_MASK;
    assign next_addr = base + {{(ADDR_WIDTH-L-2){1'b0}}, addr_cnt + 1'b1, 2'b00};
    assign req_ready = (state == S_IDLE) && !rst;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            base        <= '0;
            wr          <= 1'b0;
            wdata_q     <= '0;
            addr_cnt    <= '0;
            data_cnt    <= '0;
            data_active <= 1'b0;
            err         <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_error  <= 1'b0;
            HADDR       <= '0;
            HTRANS      <= HT_IDLE;
            HBURST      <= 3'b000;
            HSIZE       <= 3'b000;
            HWRITE      <= 1'b0;
            HWDATA      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        base        <= req_base;
                        wr          <= req_write;
                        wdata_q     <= req_wdata;
                        resp_data   <= '0;
                        resp_error  <= 1'b0;
                        err         <= 1'b0;
                        addr_cnt    <= '0;
                        data_cnt    <= '0;
                        data_active <= 1'b0;
                        HADDR       <= req_base;
                        HTRANS      <= HT_NONSEQ;
                        HBURST      <= HB_INCR8;
                        HSIZE       <= HS_WORD;
                        HWRITE      <= req_write;
                        state       <= S_BURST;
                    end
                end
                S_BURST, S_DRAIN: begin
                    if (data_active && HRESP && !HREADY) begin
                        // First error cycle: cancel the pending address phase.
                        err    <= 1'b1;
                        HTRANS <= HT_IDLE;
                        HBURST <= 3'b000;
                        HSIZE  <= 3'b000;
                        state  <= S_DRAIN;
                    end else if (HREADY) begin
                        if (data_active && !wr && !HRESP && !err)
                            resp_data[data_cnt*WORD_WIDTH +: WORD_WIDTH] <= HRDATA;
                        if (data_active)
                            data_cnt <= data_cnt + 1'b1;
                        if (state == S_DRAIN) begin
                            resp_valid  <= 1'b1;
                            resp_error  <= err;
                            data_active <= 1'b0;
                            HWRITE      <= 1'b0;
                            HWDATA      <= '0;
                            state       <= S_RESP;
                        end else begin
                            data_active <= 1'b1;
                            HWDATA      <= wdata_q[addr_cnt*WORD_WIDTH +: WORD_WIDTH];
                            if (addr_cnt == LAST_BEAT) begin
                                HTRANS <= HT_IDLE;
                                HBURST <= 3'b000;
                                HSIZE  <= 3'b000;
                                state  <= S_DRAIN;
                            end else begin
                                addr_cnt <= addr_cnt + 1'b1;
                                HADDR    <= next_addr;
                                HTRANS   <= HT_SEQ;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ahb_master.sv
// Directed bench for cache_ahb_master: a zero-wait AHB slave returning
// HRDATA = data-phase address, with per-cycle wait and error injection.
module tb_cache_ahb_master;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic [255:0] resp_data;
    logic         resp_error;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic [2:0]   HSIZE;
    logic         HWRITE;
    logic [31:0]  HWDATA;
    logic [31:0]  HRDATA;
    logic         HREADY;
    logic         HRESP;
    logic [1:0]   dbg_state;

    cache_ahb_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_error(resp_error),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Slave side: remember the address whose data phase is in progress.
    logic        dp_valid;
    logic [31:0] dp_addr;
    always @(posedge clk) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_addr  <= '0;
        end else if (HREADY) begin
            dp_valid <= HTRANS[1];
            dp_addr  <= HADDR;
        end
    end
    assign HRDATA = dp_addr;

    int n_tests = 0;
    int n_fail  = 0;

    int          resp_cycle;
    logic [31:0] acc_addr [8];
    logic [31:0] acc_wd [8];
    int          n_acc;
    int          n_wd;
    int          hold_err;
    int          seq_err;
    logic [1:0]  htrans_after_err;
    logic [1:0]  t1_htrans;
    logic [2:0]  t1_hburst;
    logic [2:0]  t1_hsize;
    logic        t1_hwrite;
    logic [31:0] t1_haddr;

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic w, input logic [31:0] a, input logic [255:0] d);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) wait_cycle();
        wait_cycle();
        req_valid = 1'b0;
    endtask

    task automatic run_burst(input logic w, input logic [31:0] a, input logic [255:0] d,
                             input logic [39:0] stall, input int err_beat);
        int          err_stage;
        logic        prev_stall;
        logic [31:0] p_addr;
        logic [31:0] p_wd;
        logic [1:0]  p_trans;
        logic        p_wr;
        start_req(w, a, d);
        resp_cycle = -1; n_acc = 0; n_wd = 0; hold_err = 0; seq_err = 0;
        htrans_after_err = 2'bxx; err_stage = 0; prev_stall = 1'b0;
        p_addr = '0; p_wd = '0; p_trans = '0; p_wr = 1'b0;
        for (int t = 1; t < 40; t++) begin
            if (err_stage == 0 && dp_valid && n_wd == err_beat) begin
                HRESP = 1'b1; HREADY = 1'b0; err_stage = 1;
            end else if (err_stage == 1) begin
                HRESP = 1'b1; HREADY = 1'b1; err_stage = 2;
                htrans_after_err = HTRANS;
            end else begin
                HRESP = 1'b0; HREADY = !stall[t];
            end
            if (t == 1) begin
                t1_htrans = HTRANS; t1_hburst = HBURST; t1_hsize = HSIZE;
                t1_hwrite = HWRITE; t1_haddr = HADDR;
            end
            if (prev_stall && (HADDR !== p_addr || HTRANS !== p_trans ||
                               HWDATA !== p_wd || HWRITE !== p_wr))
                hold_err++;
            prev_stall = !HREADY && !HRESP;
            p_addr = HADDR; p_trans = HTRANS; p_wd = HWDATA; p_wr = HWRITE;
            if (resp_valid) begin
                resp_cycle = t;
                break;
            end
            if (HREADY && HTRANS[1] && n_acc < 8) begin
                acc_addr[n_acc] = HADDR;
                if (HTRANS !== ((n_acc == 0) ? 2'b10 : 2'b11)) seq_err++;
                n_acc++;
            end
            if (HREADY && dp_valid) begin
                if (n_wd < 8) acc_wd[n_wd] = HWDATA;
                n_wd++;
            end
            wait_cycle();
        end
        HREADY = 1'b1;
        HRESP  = 1'b0;
    endtask

    task automatic retire();
        resp_ready = 1'b1;
        wait_cycle();
        resp_ready = 1'b0;
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] b, input int step, input int nwords);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < nwords; k++) l[k*32 +: 32] = b + step * k;
        return l;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        wait_cycle(); wait_cycle();
        n_tests++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_low got=%b want=0", req_ready); end
        rst = 1'b0;
        wait_cycle();
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready_idle got=%b want=1", req_ready); end
        n_tests++;
        if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_data !== '0) begin
            n_fail++; $display("FAIL reset_resp got v=%b e=%b d=%h want 0", resp_valid, resp_error, resp_data);
        end
        n_tests++;
        if (HADDR !== 32'h0 || HTRANS !== 2'b00) begin
            n_fail++; $display("FAIL reset_addr got haddr=%h htrans=%b want 0", HADDR, HTRANS);
        end
        n_tests++;
        if (HBURST !== 3'b000 || HSIZE !== 3'b000 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
            n_fail++; $display("FAIL reset_ctrl got hburst=%b hsize=%b hwrite=%b hwdata=%h want 0",
                               HBURST, HSIZE, HWRITE, HWDATA);
        end
    endtask

    task automatic test_refill();
        logic [255:0] exp_l;
        exp_l = line_of(32'h1000_0000, 4, 8);
        run_burst(1'b0, 32'h1000_0014, '0, '0, -1);
        n_tests++;
        if (resp_cycle != 10) begin n_fail++; $display("FAIL refill_latency got=%0d want=10", resp_cycle); end
        n_tests++;
        if (t1_htrans !== 2'b10 || t1_hburst !== 3'b101 || t1_hsize !== 3'b010 || t1_hwrite !== 1'b0) begin
            n_fail++; $display("FAIL refill_ctrl got htrans=%b hburst=%b hsize=%b hwrite=%b want 10/101/010/0",
                               t1_htrans, t1_hburst, t1_hsize, t1_hwrite);
        end
        n_tests++;
        if (n_acc != 8 || seq_err != 0) begin
            n_fail++; $display("FAIL refill_beats got beats=%0d seq_err=%0d want 8/0", n_acc, seq_err);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (acc_addr[k] !== 32'h1000_0000 + 4 * k) begin
                n_fail++; $display("FAIL refill_haddr[%0d] got=%h want=%h", k, acc_addr[k], 32'h1000_0000 + 4 * k);
            end
        end
        n_tests++;
        if (resp_data !== exp_l || resp_error !== 1'b0) begin
            n_fail++; $display("FAIL refill_data got=%h err=%b want=%h err=0", resp_data, resp_error, exp_l);
        end
        retire();
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL refill_retire got v=%b rdy=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_wait_states();
        logic [255:0] exp_l;
        exp_l = line_of(32'h1000_0000, 4, 8);
        run_burst(1'b0, 32'h1000_0014, '0, 40'h48, -1);
        n_tests++;
        if (resp_cycle != 12) begin n_fail++; $display("FAIL wait_latency got=%0d want=12", resp_cycle); end
        n_tests++;
        if (hold_err != 0) begin n_fail++; $display("FAIL wait_hold got=%0d changes want=0", hold_err); end
        n_tests++;
        if (resp_data !== exp_l || resp_error !== 1'b0) begin
            n_fail++; $display("FAIL wait_data got=%h err=%b want=%h err=0", resp_data, resp_error, exp_l);
        end
        retire();
    endtask

    task automatic test_write_back();
        logic [255:0] wd;
        wd = line_of(32'hA5A5_0000, 1, 8);
        run_burst(1'b1, 32'h2000_0040, wd, 40'h0, -1);
        n_tests++;
        if (t1_hwrite !== 1'b1 || t1_haddr !== 32'h2000_0040) begin
            n_fail++; $display("FAIL wb_first got hwrite=%b haddr=%h want 1/20000040", t1_hwrite, t1_haddr);
        end
        n_tests++;
        if (n_wd != 8 || resp_cycle != 10) begin
            n_fail++; $display("FAIL wb_phases got data=%0d resp_cycle=%0d want 8/10", n_wd, resp_cycle);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (acc_wd[k] !== 32'hA5A5_0000 + k) begin
                n_fail++; $display("FAIL wb_hwdata[%0d] got=%h want=%h", k, acc_wd[k], 32'hA5A5_0000 + k);
            end
        end
        n_tests++;
        if (resp_error !== 1'b0 || resp_data !== '0) begin
            n_fail++; $display("FAIL wb_resp got err=%b data=%h want 0/0", resp_error, resp_data);
        end
        retire();
    endtask

    task automatic test_error();
        logic [255:0] exp_l;
        exp_l = line_of(32'h1000_0000, 4, 3);
        run_burst(1'b0, 32'h1000_0014, '0, 40'h0, 3);
        n_tests++;
        if (htrans_after_err !== 2'b00) begin
            n_fail++; $display("FAIL err_cancel got htrans=%b want=00", htrans_after_err);
        end
        n_tests++;
        if (resp_cycle != 7 || resp_error !== 1'b1) begin
            n_fail++; $display("FAIL err_resp got cycle=%0d err=%b want 7/1", resp_cycle, resp_error);
        end
        n_tests++;
        if (resp_data !== exp_l) begin n_fail++; $display("FAIL err_data got=%h want=%h", resp_data, exp_l); end
        retire();
    endtask

    task automatic test_back_to_back();
        logic [255:0] exp_a;
        logic [255:0] exp_b;
        exp_a = line_of(32'h3000_0000, 4, 8);
        exp_b = line_of(32'h3000_0020, 4, 8);
        run_burst(1'b0, 32'h3000_0000, '0, 40'h0, -1);
        req_write = 1'b0; req_addr = 32'h3000_0020; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (resp_valid !== 1'b1 || resp_data !== exp_a || HTRANS !== 2'b00 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL b2b_stall[%0d] got v=%b htrans=%b rdy=%b data=%h want 1/00/0 %h",
                                   i, resp_valid, HTRANS, req_ready, resp_data, exp_a);
            end
            wait_cycle();
        end
        retire();
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || HTRANS !== 2'b00) begin
            n_fail++; $display("FAIL b2b_retired got v=%b rdy=%b htrans=%b want 0/1/00", resp_valid, req_ready, HTRANS);
        end
        run_burst(1'b0, 32'h3000_0020, '0, 40'h0, -1);
        n_tests++;
        if (resp_cycle != 10 || resp_data !== exp_b) begin
            n_fail++; $display("FAIL b2b_second got cycle=%0d data=%h want 10 %h", resp_cycle, resp_data, exp_b);
        end
        retire();
    endtask

    task automatic test_reset_mid_burst();
        int stray;
        logic [255:0] exp_l;
        exp_l = line_of(32'h4000_0000, 4, 8);
        start_req(1'b0, 32'h1000_0014, '0);
        for (int t = 1; t < 5; t++) wait_cycle();
        rst = 1'b1;
        wait_cycle();
        n_tests++;
        if (HTRANS !== 2'b00 || resp_valid !== 1'b0 || HADDR !== 32'h0 || HBURST !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid got htrans=%b v=%b haddr=%h hburst=%b want 00/0/0/000",
                               HTRANS, resp_valid, HADDR, HBURST);
        end
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            if (resp_valid !== 1'b0 || HTRANS !== 2'b00) stray++;
            wait_cycle();
        end
        n_tests++;
        if (stray != 0) begin n_fail++; $display("FAIL rst_no_resp got=%0d active cycles want=0", stray); end
        run_burst(1'b0, 32'h4000_0008, '0, 40'h0, -1);
        n_tests++;
        if (resp_cycle != 10 || resp_data !== exp_l || resp_error !== 1'b0) begin
            n_fail++; $display("FAIL rst_recover got cycle=%0d data=%h err=%b want 10 %h 0",
                               resp_cycle, resp_data, resp_error, exp_l);
        end
        retire();
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; HREADY = 1'b1; HRESP = 1'b0; rst = 1'b1;
        test_reset();
        test_refill();
        test_wait_states();
        test_write_back();
        test_error();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
